// File: rtl/multi_digit_segment_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadowed data, hex/BCD glyphs and leading-zero blanking.
// Latency: outputs registered one cycle behind the scan counters; load takes effect on the following edge.

module multi_digit_segment_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]            sh_dp_q, sh_dp_d;
    logic [6:0]                       seg_q, seg_d;
    logic                             dp_q, dp_d;
    logic [NUM_DIGITS-1:0]            an_q, an_d;
    logic                             frame_q, frame_d;
    logic [NUM_DIGITS-1:0]            lz_blank;
    logic                             upper_zero;
    logic [3:0]                       cur_nib;

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h7E;
            4'h1: g = 7'h30;
            4'h2: g = 7'h6D;
            4'h3: g = 7'h79;
            4'h4: g = 7'h33;
            4'h5: g = 7'h5B;
            4'h6: g = 7'h5F;
            4'h7: g = 7'h70;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h7B;
            4'hA: g = 7'h77;
            4'hB: g = 7'h1F;
            4'hC: g = 7'h4E;
            4'hD: g = 7'h3D;
            4'hE: g = 7'h4F;
            default: g = 7'h47;
        endcase
        // BCD mode shows a dash for anything that is not a decimal digit
        if (!hex && (nib > 4'd9)) begin
            g = 7'h01;
        end
        return g;
    endfunction

    // Walk down from the most significant digit; a digit blanks while everything above it is zero
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero  = upper_zero & (sh_dig_q[i] == 4'd0);
            lz_blank[i] = blank_lz & upper_zero;
        end
    end

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            sh_dig_d = digits;
            sh_dp_d  = dp;
        end

        cur_nib = sh_dig_q[idx_q];
        seg_d   = lz_blank[idx_q] ? 7'h00 : glyph(cur_nib, hex_mode);
        dp_d    = sh_dp_q[idx_q];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (cnt_q >= CNT_BLANK) && (idx_q == IDX_W'(i));
        end
        frame_d = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            an_q     <= '0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    // Pin polarity is a pure inversion after all logic; frame is an internal strobe and stays active-high
    assign seg    = seg_q ^ {7{ACTIVE_LOW}};
    assign dp_out = dp_q ^ ACTIVE_LOW;
    assign an     = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign frame  = frame_q;

endmodule

// File: tb/tb_multi_digit_segment_driver.sv
// Bench for multi_digit_segment_driver: positional scan model, glyph vector table, hand sequences and random traffic.
module tb_multi_digit_segment_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load, hex_mode, blank_lz;
    logic [6:0]  seg, seg_n;
    logic        dp_out, dp_out_n;
    logic [3:0]  an, an_n;
    logic        frame, frame_n;

    int total = 0;
    int bad   = 0;

    // Model: pos = edges since reset release, shadow copy of the last loaded data
    int          pos;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;
    logic [3:0]  e_an;
    logic [6:0]  glyph_tab [16];

    always #5 clk = ~clk;

    multi_digit_segment_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .reset(reset), .digits(digits), .dp(dp), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .seg(seg), .dp_out(dp_out), .an(an), .frame(frame)
    );

    multi_digit_segment_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .reset(reset), .digits(digits), .dp(dp), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .seg(seg_n), .dp_out(dp_out_n), .an(an_n), .frame(frame_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [15:0] val, input int d, input logic hex, input logic blz);
        logic [15:0] upper;
        int          nib;
        upper = val >> (4 * d);
        nib   = int'(upper & 16'hF);
        if (blz && d > 0 && upper == 16'h0) return 7'h00;
        if (!hex && nib > 9) return 7'h01;
        return glyph_tab[nib];
    endfunction

    // One clock edge: advance model with the inputs seen at the edge, then compare both instances
    task automatic tick();
        int         slot, off;
        logic [6:0] inv_seg;
        logic [3:0] inv_an;
        @(posedge clk);
        if (reset) begin
            e_seg = '0; e_dp = 1'b0; e_an = '0; e_frame = 1'b0;
            pos = 0; m_dig = '0; m_dp = '0;
        end else begin
            slot    = (pos / RD) % ND;
            off     = pos % RD;
            e_an    = (off < BC) ? 4'b0000 : (4'b0001 << slot);
            e_seg   = ref_seg(m_dig, slot, hex_mode, blank_lz);
            e_dp    = m_dp[slot];
            e_frame = ((pos % (ND * RD)) == ND * RD - 1);
            pos++;
            if (load) begin
                m_dig = digits;
                m_dp  = dp;
            end
        end
        #1;
        inv_seg = ~e_seg;
        inv_an  = ~e_an;
        chk("seg", seg, e_seg);
        chk("dp_out", dp_out, e_dp);
        chk("an", an, e_an);
        chk("frame", frame, e_frame);
        chk("seg_pin_low", seg_n, inv_seg);
        chk("dp_pin_low", dp_out_n, !e_dp);
        chk("an_pin_low", an_n, inv_an);
        chk("frame_low_inst", frame_n, e_frame);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit hit;
        hit = 0;
        for (int n = 0; n < 24 && !hit; n++) begin
            tick();
            if (an == target) hit = 1;
        end
        if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpv;
        logic        hex;
        logic        blz;
        int          d;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int cnt_frames, cnt_d0, cnt_bad_glyph;

        glyph_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        vecs = '{
            '{16'h00AF, 4'b0000, 1'b0, 1'b0, 0, 7'h01, 1'b0},
            '{16'h00AF, 4'b0000, 1'b0, 1'b0, 1, 7'h01, 1'b0},
            '{16'h00AF, 4'b0000, 1'b1, 1'b0, 0, 7'h47, 1'b0},
            '{16'h00AF, 4'b0000, 1'b1, 1'b0, 1, 7'h77, 1'b0},
            '{16'h00AF, 4'b0000, 1'b1, 1'b0, 2, 7'h7E, 1'b0},
            '{16'h0050, 4'b0000, 1'b0, 1'b1, 3, 7'h00, 1'b0},
            '{16'h0050, 4'b0000, 1'b0, 1'b1, 2, 7'h00, 1'b0},
            '{16'h0050, 4'b0000, 1'b0, 1'b1, 1, 7'h5B, 1'b0},
            '{16'h0050, 4'b0000, 1'b0, 1'b1, 0, 7'h7E, 1'b0},
            '{16'h0000, 4'b0000, 1'b0, 1'b1, 0, 7'h7E, 1'b0},
            '{16'h0000, 4'b0000, 1'b0, 1'b1, 1, 7'h00, 1'b0},
            '{16'h0000, 4'b0000, 1'b1, 1'b1, 3, 7'h00, 1'b0},
            '{16'h0000, 4'b0100, 1'b0, 1'b1, 2, 7'h00, 1'b1},
            '{16'h0050, 4'b0000, 1'b0, 1'b0, 3, 7'h7E, 1'b0},
            '{16'h1234, 4'b1000, 1'b0, 1'b0, 3, 7'h30, 1'b1},
            '{16'h1234, 4'b1000, 1'b0, 1'b0, 0, 7'h33, 1'b0},
            '{16'h00A0, 4'b0000, 1'b0, 1'b1, 1, 7'h01, 1'b0},
            '{16'h00A0, 4'b0000, 1'b0, 1'b1, 2, 7'h00, 1'b0}
        };

        reset = 1'b1; digits = '0; dp = '0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
        pos = 0; m_dig = '0; m_dp = '0;
        repeat (3) tick();
        chk("reset_an", an, 4'b0000);
        chk("reset_an_pin_low", an_n, 4'b1111);
        chk("reset_seg_pin_low", seg_n, 7'h7F);

        // First digit after release; digit 0 of 0x1234 is nibble 4
        reset = 1'b0; digits = 16'h1234; load = 1'b1;
        tick();
        chk("first_edge_an", an, 4'b0000);
        load = 1'b0;
        tick();
        chk("second_edge_an", an, 4'b0001);
        chk("second_edge_seg", seg, 7'h33);
        repeat (4) tick();
        chk("next_slot_an", an, 4'b0010);
        chk("next_slot_seg", seg, 7'h79);

        // Cadence over two full scans
        cnt_frames = 0; cnt_d0 = 0;
        for (int n = 0; n < 32; n++) begin
            tick();
            if (frame) cnt_frames++;
            if (an == 4'b0001) cnt_d0++;
        end
        chk("frames_in_32", cnt_frames, 2);
        chk("digit0_cycles_in_32", cnt_d0, 6);

        // Glyph / blanking table
        foreach (vecs[v]) begin
            digits = vecs[v].dig; dp = vecs[v].dpv; hex_mode = vecs[v].hex; blank_lz = vecs[v].blz;
            load = 1'b1;
            tick();
            load = 1'b0;
            wait_an(4'b0001 << vecs[v].d, "vec_wait");
            chk($sformatf("vec%0d_seg", v), seg, vecs[v].exp_seg);
            chk($sformatf("vec%0d_dp", v), dp_out, vecs[v].exp_dp);
        end

        // Double buffering: unloaded input changes stay invisible for three frames
        digits = 16'h5678; dp = 4'b0000; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0; digits = 16'h9999;
        cnt_bad_glyph = 0;
        for (int n = 0; n < 3 * ND * RD; n++) begin
            tick();
            if (seg == 7'h7B) cnt_bad_glyph++;
        end
        chk("unloaded_glyph_seen", cnt_bad_glyph, 0);
        wait_an(4'b0001, "dbuf_wait");
        chk("dbuf_old_glyph", seg, 7'h7F);
        load = 1'b1;
        tick();
        chk("load_edge_old_glyph", seg, 7'h7F);
        load = 1'b0;
        tick();
        chk("load_next_edge_new_glyph", seg, 7'h7B);
        chk("load_next_edge_same_slot", an, 4'b0001);

        // Reset in digit 2's slot
        wait_an(4'b0100, "midscan_wait");
        reset = 1'b1;
        tick();
        chk("midscan_reset_an", an, 4'b0000);
        chk("midscan_reset_seg", seg, 7'h00);
        chk("midscan_reset_seg_pin_low", seg_n, 7'h7F);
        chk("midscan_reset_an_pin_low", an_n, 4'b1111);
        reset = 1'b0;
        tick();
        chk("restart_blank_an", an, 4'b0000);
        tick();
        chk("restart_digit0_an", an, 4'b0001);
        chk("restart_digit0_pin_low", an_n, 4'b1110);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            digits   = 16'($urandom);
            dp       = 4'($urandom);
            hex_mode = 1'($urandom);
            blank_lz = 1'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
            tick();
        end
        reset = 1'b0; load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
